uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Receive-side frame sequencer for the UART slave. Consumes the per-bit unanimity flags of the RX bit checker on each oversample tick, tracks start, data, optional parity and stop bits with a state machine and tick counter, and assembles an LSB-first data word. Presents the word with a one-cycle valid strobe plus framing, parity and noise error flags to the host-side register logic.

## Interface

- DATA_BITS, 8, data bits per frame (5..9)
- OVERSAMPLE, 4, baud ticks per bit; equals the bit checker window depth
- PARITY_EN, 0, 1 = one parity bit follows the data
- PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN = 0)

- i_clk  in  1  system clock; all logic on rising edge
- i_rst_n  in  1  synchronous active-low reset, sampled on rising i_clk
- i_baudclk  in  1  oversample tick, one i_clk cycle wide; same tick that shifts the bit checker
- i_zerodetected  in  1  bit checker: all samples in window = 0
- i_onedetected  in  1  bit checker: all samples in window = 1
- i_rx_en  in  1  receiver enable
- o_data  out  DATA_BITS  last received word, LSB = first bit on line
- o_valid  out  1  one-cycle strobe, o_data updated and error-free
- o_frame_err  out  1  one-cycle strobe, stop bit not 1
- o_parity_err  out  1  one-cycle strobe, parity mismatch
- o_noise_err  out  1  one-cycle strobe, at least one bit neither all-0 nor all-1
- o_busy  out  1  high in any state other than IDLE

## Operation

- States: IDLE, DATA, PARITY, STOP, WAIT_IDLE. Tick counter tcnt (0..OVERSAMPLE-1), bit counter bcnt (0..DATA_BITS-1), shift register, running parity, sticky noise flag.
- All state changes happen only on i_clk edges with i_baudclk = 1; flags are ignored on non-tick cycles.
- IDLE: i_rx_en = 1 and tick with i_zerodetected = 1 -> start bit confirmed; tcnt = 0, bcnt = 0, parity and noise cleared; go to DATA. Any other tick -> stay.
- Bit evaluation: each tick increments tcnt; on the tick where tcnt = OVERSAMPLE-1 the bit is decided, tcnt wraps to 0. Value = i_onedetected. If neither flag is set, set noise flag (value still = i_onedetected = 0). Both flags set cannot occur; treat as noise, value 1.
- DATA: decided bit shifted in at MSB, shift right (LSB-first); parity XOR updated; after bit DATA_BITS-1 -> PARITY if PARITY_EN else STOP.
- PARITY: decided bit XORed into parity; parity error if (parity XOR PARITY_ODD) != 0 -> STOP.
- STOP: decided bit = 1 -> copy shift register to o_data; o_valid = 1 only if no parity and no noise error; otherwise that error strobe; -> IDLE. Decided bit = 0 -> o_frame_err; o_data not updated; -> WAIT_IDLE.
- Noise and parity error strobes fire at the STOP decision and update o_data (bad word is visible). Frame error suppresses o_valid and all other strobes.
- WAIT_IDLE: stays until a tick with i_onedetected = 1 (line break guard) -> IDLE.
- i_rx_en = 0: blocks only the IDLE -> DATA transition; a frame in progress completes.

## Timing

- Reset: state IDLE, counters 0, o_data = 0, o_valid, o_frame_err, o_parity_err, o_noise_err, o_busy = 0. Reset mid-frame abandons the frame with no strobe.
- o_busy rises the cycle after the start-confirming tick and falls the cycle after the STOP decision (or when leaving WAIT_IDLE).
- Strobes and o_data update are registered: asserted exactly one i_clk cycle after the STOP decision tick, for one cycle.
- Frame length from start-confirm tick to STOP decision tick = (DATA_BITS + PARITY_EN + 1) x OVERSAMPLE ticks.
- A start can be confirmed on the first tick after returning to IDLE; back-to-back frames need no idle gap.
- o_data holds its value until the next accepted stop bit; no overrun detection.

## Test plan

- Reset, then byte 0xA5, 8N1, OVERSAMPLE 4 -> o_valid one cycle with o_data = 0xA5, no error strobes, o_busy high 36 ticks.
- PARITY_EN = 1, even, send 0x37 with correct parity 1 -> o_valid, data 0x37; resend with parity 0 -> o_parity_err, o_data = 0x37, no o_valid.
- Send 0x55 with stop bit 0 and line held low 20 bit times -> o_frame_err once, o_data unchanged, state WAIT_IDLE until line high, no new start detected.
- Bit 3 of 0xF0 glitched (mixed samples) -> o_noise_err at stop, no o_valid.
- Two frames 0x01, 0xFE back-to-back with no idle gap -> two o_valid strobes, values in order.
- i_rst_n low during bit 4 of a frame -> all outputs 0 next cycle, no strobe; i_rx_en = 0 with start applied -> o_busy stays 0.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: start/data/parity/stop tracking on oversample ticks,
// LSB-first word assembly and registered valid/error strobes.
module uart_rx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_baudclk,
    input  logic                 i_zerodetected,
    input  logic                 i_onedetected,
    input  logic                 i_rx_en,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_noise_err,
    output logic                 o_busy
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TCNT_MAX = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BCNT_MAX = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [TW-1:0]         r_tcnt;
    logic [BW-1:0]         r_bcnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_par;
    logic                  r_perr;
    logic                  r_noise;

    logic w_decide;
    logic w_bit;
    logic w_bit_noise;
    logic w_noise_any;
    logic w_stop_ok;
    logic w_stop_bad;

    // Both flags set is impossible from a sane checker; it is folded into noise with value 1.
    assign w_bit       = i_onedetected;
    assign w_bit_noise = ~(i_zerodetected ^ i_onedetected);
    assign w_decide    = i_baudclk && (r_tcnt == TCNT_MAX);
    assign w_noise_any = r_noise | w_bit_noise;
    assign o_busy      = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_stop_ok   = 1'b0;
        w_stop_bad  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_baudclk && i_rx_en && i_zerodetected)
                    w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_decide && (r_bcnt == BCNT_MAX))
                    w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (w_decide)
                    w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (w_decide) begin
                    w_stop_ok   = w_bit;
                    w_stop_bad  = ~w_bit;
                    w_state_nxt = w_bit ? S_IDLE : S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (i_baudclk && i_onedetected)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_tcnt       <= '0;
            r_bcnt       <= '0;
            r_par        <= 1'b0;
            r_perr       <= 1'b0;
            r_noise      <= 1'b0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
            o_noise_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            o_valid      <= w_stop_ok && !r_perr && !w_noise_any;
            o_parity_err <= w_stop_ok && r_perr;
            o_noise_err  <= w_stop_ok && w_noise_any;
            o_frame_err  <= w_stop_bad;
            if (w_stop_ok)
                o_data <= r_shift;

            if (r_state == S_IDLE) begin
                r_tcnt  <= '0;
                r_bcnt  <= '0;
                r_par   <= 1'b0;
                r_perr  <= 1'b0;
                r_noise <= 1'b0;
            end else if (i_baudclk && (r_state != S_WAIT_IDLE)) begin
                r_tcnt <= w_decide ? '0 : r_tcnt + 1'b1;
                if (w_decide) begin
                    r_noise <= r_noise | w_bit_noise;
                    if (r_state == S_DATA) begin
                        r_par  <= r_par ^ w_bit;
                        r_bcnt <= (r_bcnt == BCNT_MAX) ? '0 : r_bcnt + 1'b1;
                    end
                    if (r_state == S_PARITY)
                        r_perr <= r_par ^ w_bit ^ (PARITY_ODD != 0);
                end
            end
        end
    end

    // Data path shift register: no reset needed, only read on an accepted stop bit.
    always_ff @(posedge i_clk) begin
        if (w_decide && (r_state == S_DATA))
            r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: an 8N1 instance and an 8E1 instance share the
// bit-checker stimulus; each has its own expected-strobe queue and monitor.
module tb_uart_rx_ctrl;

    localparam int OS      = 4;
    localparam int TICKPER = 2;

    typedef struct packed {
        logic [3:0] flags;   // {valid, frame, parity, noise}
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud = 1'b0;
    logic       zd = 1'b0;
    logic       od = 1'b1;
    logic       en0 = 1'b0;
    logic       en1 = 1'b0;
    logic [7:0] d0, d1;
    logic       v0, f0, p0, n0, b0;
    logic       v1, f1, p1, n1, b1;

    int   checks = 0;
    int   errors = 0;
    int   run0 = 0;
    int   last_run0 = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_baudclk(baud),
        .i_zerodetected(zd), .i_onedetected(od), .i_rx_en(en0),
        .o_data(d0), .o_valid(v0), .o_frame_err(f0), .o_parity_err(p0),
        .o_noise_err(n0), .o_busy(b0)
    );

    uart_rx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_baudclk(baud),
        .i_zerodetected(zd), .i_onedetected(od), .i_rx_en(en1),
        .o_data(d1), .o_valid(v1), .o_frame_err(f1), .o_parity_err(p1),
        .o_noise_err(n1), .o_busy(b1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && ({v0, f0, p0, n0} != 4'b0)) begin
            if (q0.size() == 0) begin
                check("dut0 unexpected strobe", {28'b0, v0, f0, p0, n0}, 32'd0);
            end else begin
                e0 = q0.pop_front();
                check("dut0 strobes", {28'b0, v0, f0, p0, n0}, {28'b0, e0.flags});
                check("dut0 data", {24'b0, d0}, {24'b0, e0.data});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ({v1, f1, p1, n1} != 4'b0)) begin
            if (q1.size() == 0) begin
                check("dut1 unexpected strobe", {28'b0, v1, f1, p1, n1}, 32'd0);
            end else begin
                e1 = q1.pop_front();
                check("dut1 strobes", {28'b0, v1, f1, p1, n1}, {28'b0, e1.flags});
                check("dut1 data", {24'b0, d1}, {24'b0, e1.data});
            end
        end
    end

    always @(negedge clk) begin
        if (b0 === 1'b1) begin
            run0 <= run0 + 1;
        end else if (run0 > 0) begin
            last_run0 <= run0;
            run0      <= 0;
        end
    end

    // Non-tick cycles carry a start-like pattern that the DUT must ignore.
    task automatic tick(input logic z, input logic o);
        @(posedge clk); #1;
        baud = 1'b1; zd = z; od = o;
        @(posedge clk); #1;
        baud = 1'b0; zd = 1'b1; od = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b1);
    endtask

    task automatic send_bit(input logic b, input bit noisy);
        repeat (OS) begin
            if (noisy) tick(1'b0, 1'b0);
            else       tick(~b, b);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input bit use_par, input logic par,
                              input logic stop, input int noise_idx);
        tick(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i], i == noise_idx);
        if (use_par) send_bit(par, 1'b0);
        send_bit(stop, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst data", {24'b0, d0}, 32'h00);
        check("rst strobes", {28'b0, v0, f0, p0, n0}, 32'd0);
        check("rst busy", {31'b0, b0}, 32'd0);
        check("rst dut1 outs", {23'b0, d1, b1}, 32'd0);
        rst_n = 1'b1;

        en0 = 1'b1;
        idle(3);
        q0.push_back({4'b1000, 8'hA5});
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1);
        idle(2);
        check("busy length A5", last_run0, 36 * TICKPER);
        check("busy after A5", {31'b0, b0}, 32'd0);

        q0.push_back({4'b0100, 8'hA5});
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1);
        check("busy wait_idle entry", {31'b0, b0}, 32'd1);
        repeat (20 * OS) tick(1'b1, 1'b0);
        check("busy line low", {31'b0, b0}, 32'd1);
        tick(1'b0, 1'b1);
        check("busy line high", {31'b0, b0}, 32'd0);
        idle(4);
        check("no false start", {31'b0, b0}, 32'd0);
        check("data kept after frame err", {24'b0, d0}, 32'hA5);

        q0.push_back({4'b0001, 8'hF0});
        send_frame(8'hF0, 1'b0, 1'b0, 1'b1, 3);
        idle(2);

        q0.push_back({4'b1000, 8'h01});
        q0.push_back({4'b1000, 8'hFE});
        send_frame(8'h01, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'hFE, 1'b0, 1'b0, 1'b1, -1);
        idle(2);
        check("data after b2b", {24'b0, d0}, 32'hFE);

        en0 = 1'b0;
        repeat (8) tick(1'b1, 1'b0);
        check("busy rx_en off", {31'b0, b0}, 32'd0);
        idle(2);
        en0 = 1'b1;

        tick(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(8'h3C >> i, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        check("busy mid frame", {31'b0, b0}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid rst data", {24'b0, d0}, 32'h00);
        check("mid rst strobes+busy", {27'b0, v0, f0, p0, n0, b0}, 32'd0);
        rst_n = 1'b1;
        idle(20);
        check("no strobe after rst", {31'b0, b0}, 32'd0);

        en0 = 1'b0;
        en1 = 1'b1;
        idle(2);
        q1.push_back({4'b1000, 8'h37});
        send_frame(8'h37, 1'b1, 1'b1, 1'b1, -1);
        idle(2);
        q1.push_back({4'b0010, 8'h37});
        send_frame(8'h37, 1'b1, 1'b0, 1'b1, -1);
        idle(2);
        q1.push_back({4'b1000, 8'h00});
        send_frame(8'h00, 1'b1, 1'b0, 1'b1, -1);
        idle(4);
        check("dut1 data final", {24'b0, d1}, 32'h00);
        check("dut0 idle during dut1", {31'b0, b0}, 32'd0);

        check("q0 drained", q0.size(), 32'd0);
        check("q1 drained", q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
